vga_sync_decoder: RTL and testbench

// Receive-side counterpart of the 640x480 VGA timing generator: samples hsync/vsync/RGB222 on the pixel clock and recovers pixel x/y.

---
 rtl/vga_sync_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// ----------------
// Receive-side VGA timing decoder. Samples hsync/vsync/RGB222 on the pixel
// clock, recovers the pixel coordinates, measures line and frame timing and
// declares lock after LOCK_FRAMES consecutive conformant frames.
//
// Ports
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   hsync_in     incoming horizontal sync (polarity set by SYNC_ACTIVE_LOW)
//   vsync_in     incoming vertical sync
//   rgb_in       {R[1:0],G[1:0],B[1:0]}
//   pix_x/pix_y  coordinates in the active area, 0 when !pix_valid
//   pix_valid    active-video pixel present this cycle
//   pix_rgb      colour aligned with pix_x/pix_y, 0 when !pix_valid
//   frame_start  1-cycle pulse on each detected vsync leading edge
//   locked       timing has been conformant for LOCK_FRAMES frames
//   line_len     length in clocks of the last measured line
//   frame_lines  line count of the last completed frame
//
// Output stream: pix_valid is a valid-only qualifier with no ready; the
// consumer must take pix_x/pix_y/pix_rgb on every cycle pix_valid is high,
// and those buses read 0 whenever pix_valid is low.
//
// Input-to-output latency is SYNC_STAGES+1 clocks: SYNC_STAGES synchroniser
// flops, then one registered output stage. The edge detector compares the
// last synchroniser stage with a one-cycle-old copy, so it adds no latency to
// the data path.
module vga_sync_decoder #(
    parameter int H_ACTIVE        = 640,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int V_TOTAL         = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES     = 2,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [5:0]  rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [5:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam logic [10:0] H_LO      = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_HI      = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
    localparam logic [9:0]  V_LO      = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_HI      = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_FULL    = 10'(V_TOTAL);
    localparam logic [10:0] H_TIMEOUT = 11'(2 * H_TOTAL);
    // vcnt is 10 bits and saturates at 1023, so a 2*V_TOTAL limit that does
    // not fit is clipped to the saturation value to stay reachable.
    localparam logic [9:0]  V_TIMEOUT = (2 * V_TOTAL > 1023) ? 10'h3FF : 10'(2 * V_TOTAL);
    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
    localparam logic        POL       = SYNC_ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACKING = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Input synchronisers.
    logic [SYNC_STAGES-1:0] hs_sr;
    logic [SYNC_STAGES-1:0] vs_sr;
    logic [5:0]             rgb_sr [SYNC_STAGES];
    logic                   hs_prev;
    logic                   vs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_sr   <= '0;
            vs_sr   <= '0;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) rgb_sr[i] <= '0;
        end else begin
            hs_sr[0]  <= hsync_in;
            vs_sr[0]  <= vsync_in;
            rgb_sr[0] <= rgb_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                hs_sr[i]  <= hs_sr[i-1];
                vs_sr[i]  <= vs_sr[i-1];
                rgb_sr[i] <= rgb_sr[i-1];
            end
            hs_prev <= hs_sr[SYNC_STAGES-1];
            vs_prev <= vs_sr[SYNC_STAGES-1];
        end
    end

    // Leading edge = transition into the asserted level. XOR with POL maps
    // the raw level to "asserted".
    logic h_edge;
    logic v_edge;
    assign h_edge = (hs_sr[SYNC_STAGES-1] ^ POL) & ~(hs_prev ^ POL);
    assign v_edge = (vs_sr[SYNC_STAGES-1] ^ POL) & ~(vs_prev ^ POL);

    // Counters and measurement state.
    state_t      state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [10:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [9:0]  vcnt_q, vcnt_d, vcnt_inc;
    logic        h_seen_q;    // an hsync edge has been seen since reset/unlock
    logic        line_err_q;  // a non-conformant line occurred this frame
    logic        cur_line_bad;
    logic        frame_bad;
    logic        timeout;
    logic        active_d;

    always_comb begin
        hcnt_inc = (hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1;
        vcnt_inc = (vcnt_q == 10'h3FF) ? vcnt_q : vcnt_q + 10'd1;

        hcnt_d = h_edge ? 11'd0 : hcnt_inc;
        vcnt_d = vcnt_q;
        if (v_edge) vcnt_d = 10'd0;
        else if (h_edge) vcnt_d = vcnt_inc;

        // A line ending on this edge is H_TOTAL long when the count before
        // the edge was H_TOTAL-1; the first edge after reset/unlock only
        // starts the measurement.
        cur_line_bad = h_edge && h_seen_q && (hcnt_q != H_LAST);
        // vcnt counts hsync edges after the vsync edge, so the line that
        // carried the vsync edge is the +1 in the frame's line count.
        frame_bad    = line_err_q || cur_line_bad || (vcnt_inc != V_FULL);
        timeout      = (hcnt_d >= H_TIMEOUT) || (vcnt_d >= V_TIMEOUT);
    end

    // Lock FSM, next-state logic. Timeout overrides everything.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (timeout) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 4'd0;
        end else if (v_edge) begin
            case (state_q)
                ST_UNLOCKED: begin
                    state_d    = ST_TRACKING;
                    good_cnt_d = 4'd0;
                end
                ST_TRACKING: begin
                    if (frame_bad) begin
                        good_cnt_d = 4'd0;
                    end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (frame_bad) begin
                        state_d    = ST_TRACKING;
                        good_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d    = ST_UNLOCKED;
                    good_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Coordinates of the sample currently at the last synchroniser stage are
    // the counters' next values; they are trusted only once tracking.
    assign active_d = (state_d != ST_UNLOCKED) &&
                      (hcnt_d >= H_LO) && (hcnt_d <= H_HI) &&
                      (vcnt_d >= V_LO) && (vcnt_d <= V_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNLOCKED;
            good_cnt_q  <= 4'd0;
            hcnt_q      <= 11'd0;
            vcnt_q      <= 10'd0;
            h_seen_q    <= 1'b0;
            line_err_q  <= 1'b0;
            line_len    <= 11'd0;
            frame_lines <= 10'd0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            pix_valid   <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 6'd0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;

            if (timeout) h_seen_q <= 1'b0;
            else if (h_edge) h_seen_q <= 1'b1;

            if (h_edge && h_seen_q) line_len <= hcnt_inc;

            if (v_edge || timeout) line_err_q <= 1'b0;
            else if (cur_line_bad) line_err_q <= 1'b1;

            // Only a frame opened by a previous vsync edge is a measurement.
            if (v_edge && !timeout && state_q != ST_UNLOCKED) frame_lines <= vcnt_inc;

            frame_start <= v_edge;
            locked      <= (state_d == ST_LOCKED);
            pix_valid   <= active_d;
            pix_x       <= active_d ? 10'(hcnt_d - H_LO) : 10'd0;
            pix_y       <= active_d ? (vcnt_d - V_LO) : 10'd0;
            pix_rgb     <= active_d ? rgb_sr[SYNC_STAGES-1] : 6'd0;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder. The DUT runs with a scaled-down raster
// (32 clocks x 20 lines, active 16x12 starting at h=8, v=5) so each frame
// is only 640 clocks; the timing rules are identical to the 640x480 case.
module tb_vga_sync_decoder;

    localparam int HT = 32;
    localparam int VT = 20;
    localparam int HS = 4;
    localparam int HB = 4;
    localparam int HA = 16;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 12;
    localparam int LAT = 3;  // SYNC_STAGES + 1

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [5:0]  rgb_in = 6'd0;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic [5:0]  pix_rgb;
    logic        frame_start;
    logic        locked;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    // Clock and cycle stamp.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard.
    int n_checks = 0;
    int n_fail   = 0;
    logic [57:0] pix_q[$];  // {stamp, x, y, rgb}
    logic [53:0] fr_q[$];   // {stamp, frame_lines, locked, line_len}
    logic [31:0] lk_q[$];   // stamp of a locked 1->0 transition
    logic        expect_on = 1'b0;
    int          last_hedge = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops whenever the DUT presents an event.
    logic locked_prev = 1'b0;
    always @(negedge clk) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) check("pix_unexpected", {32'(cyc), pix_x, pix_y, pix_rgb}, 64'd0);
            else check("pix", {32'(cyc), pix_x, pix_y, pix_rgb}, pix_q.pop_front());
        end else begin
            check("pix_zero_when_invalid", {pix_x, pix_y, pix_rgb}, 64'd0);
        end
        if (frame_start) begin
            if (fr_q.size() == 0) check("frame_start_unexpected", {32'(cyc), frame_lines, locked, line_len}, 64'd0);
            else check("frame_start", {32'(cyc), frame_lines, locked, line_len}, fr_q.pop_front());
        end
        if (locked_prev && !locked) begin
            if (lk_q.size() == 0) check("lock_drop_unexpected", 32'(cyc), 64'd0);
            else check("lock_drop", 32'(cyc), lk_q.pop_front());
        end
        locked_prev = locked;
    end

    // Driver tasks.
    task automatic drive_sample(input logic hs, input logic vs, input logic [5:0] rgb);
        @(negedge clk);
        hsync_in = hs;
        vsync_in = vs;
        rgb_in   = rgb;
    endtask

    // Drive nlines lines of a frame (negative syncs). The expectations given
    // describe the outputs at this frame's own vsync leading edge, i.e. the
    // measurement of the frame just ended.
    task automatic drive_frame(input int nlines, input int stretch,
                               input logic [9:0] e_lines, input logic e_lock,
                               input logic [10:0] e_len, input logic e_fall);
        logic [5:0] rgb;
        for (int l = 0; l < nlines; l++) begin
            for (int h = 0; h < ((l == stretch) ? HT + 1 : HT); h++) begin
                rgb = 6'($urandom_range(0, 63));
                if (l == VS + VB + 3 && h == HS + HB + 5) rgb = 6'h2A;
                drive_sample(!(h < HS), !(l < VS), rgb);
                if (h == 0) last_hedge = cyc;
                if (l == 0 && h == 0) begin
                    fr_q.push_back({32'(cyc + LAT), e_lines, e_lock, e_len});
                    if (e_fall) lk_q.push_back(32'(cyc + LAT));
                end
                if (expect_on && h >= HS + HB && h < HS + HB + HA && l >= VS + VB && l < VS + VB + VA)
                    pix_q.push_back({32'(cyc + LAT), 10'(h - HS - HB), 10'(l - VS - VB), rgb});
            end
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) drive_sample(1'b1, 1'b1, 6'd0);
    endtask

    initial begin
        // Reset held with random inputs: every output stays 0.
        for (int i = 0; i < 6; i++) begin
            drive_sample(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
            check("rst_pix_valid", pix_valid, 0);
            check("rst_locked", locked, 0);
            check("rst_frame_start", frame_start, 0);
            check("rst_line_len", line_len, 0);
            check("rst_frame_lines", frame_lines, 0);
            check("rst_pix_bus", {pix_x, pix_y, pix_rgb}, 0);
        end
        @(negedge clk);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        rgb_in   = 6'd0;
        rst_n    = 1'b1;
        drive_idle(4);

        expect_on = 1'b1;
        // Ideal stream: lock at the third vsync edge.
        drive_frame(VT, -1, 10'd0,  1'b0, 11'd0,  1'b0);
        drive_frame(VT, -1, 10'd20, 1'b0, 11'd32, 1'b0);
        drive_frame(VT, -1, 10'd20, 1'b1, 11'd32, 1'b0);
        // Locked; this frame carries the (5,3)=2A pixel and a 33-clock last line.
        drive_frame(VT, VT - 1, 10'd20, 1'b1, 11'd32, 1'b0);
        // Stretched line makes the previous frame bad: lock drops, then relocks.
        drive_frame(VT, -1, 10'd20, 1'b0, 11'd33, 1'b1);
        drive_frame(VT, -1, 10'd20, 1'b0, 11'd32, 1'b0);
        // Relocked; this frame is one line short.
        drive_frame(VT - 1, -1, 10'd20, 1'b1, 11'd32, 1'b0);
        drive_frame(VT, -1, 10'd19, 1'b0, 11'd32, 1'b1);
        drive_frame(VT, -1, 10'd20, 1'b0, 11'd32, 1'b0);
        drive_frame(VT, -1, 10'd20, 1'b1, 11'd32, 1'b0);

        // Locked, then hsync disappears after line 5: lock drops 2*HT clocks
        // after the last hsync edge.
        drive_frame(6, -1, 10'd20, 1'b1, 11'd32, 1'b0);
        lk_q.push_back(32'(last_hedge + 2 * HT + LAT));
        expect_on = 1'b0;
        drive_idle(2 * HT + 16);

        // Restore: first edge only starts tracking (old measurements held),
        // relock on the third vsync edge.
        expect_on = 1'b1;
        drive_frame(VT, -1, 10'd20, 1'b0, 11'd32, 1'b0);
        drive_frame(VT, -1, 10'd20, 1'b0, 11'd32, 1'b0);
        drive_frame(VT, -1, 10'd20, 1'b1, 11'd32, 1'b0);
        drive_idle(8);

        check("pix_q_drained", pix_q.size(), 0);
        check("frame_q_drained", fr_q.size(), 0);
        check("lock_q_drained", lk_q.size(), 0);
        check("final_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
